// File: rtl/ysyx_23060191_mem_arbiter_pkg.sv
// Shared types for the IFU/LSU data-memory arbiter: FSM states, owner
// encoding and the watchdog counter sizing helper.
package ysyx_23060191_mem_arbiter_pkg;

    localparam int CPU_WIDTH = 32;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_WAIT = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    // Watchdog counter width; a disabled watchdog still needs a 1-bit vector.
    function automatic int cnt_width(input int timeout_cyc);
        return (timeout_cyc > 0) ? $clog2(timeout_cyc + 1) : 1;
    endfunction

endpackage

// File: rtl/ysyx_23060191_mem_arbiter_rr_pick.sv
// Two-way round-robin picker: a lone requester wins outright, a tie goes to
// the side that was not granted last. Output is one-hot, [0]=IFU, [1]=LSU.
module ysyx_23060191_rr_pick
    import ysyx_23060191_mem_arbiter_pkg::*;
(
    input  logic       ifu_valid,
    input  logic       lsu_valid,
    input  owner_e     last_grant,
    output logic [1:0] grant
);

    // Select the winner from the current valids and the previous grant.
    always_comb begin
        // NOTE: assign a default before any branch so no path can infer a latch.
        grant = 2'b00;
        if (ifu_valid && lsu_valid) begin
            grant = (last_grant == OWN_IFU) ? 2'b10 : 2'b01;
        end else if (ifu_valid) begin
            grant = 2'b01;
        end else if (lsu_valid) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/ysyx_23060191_mem_arbiter.sv
// Shares the single data-memory port between IFU fetches and LSU loads/stores.
// One outstanding transaction: IDLE grants and latches the payload, REQ holds
// it until the memory accepts, WAIT forwards the response (or a watchdog error).
module ysyx_23060191_mem_arbiter
    import ysyx_23060191_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = CPU_WIDTH,
    parameter int DATA_W      = CPU_WIDTH,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                clk,
    input  logic                rst,
    // IFU side
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic                ifu_err,
    // LSU side
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_err,
    // memory side
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int               CNT_W    = cnt_width(TIMEOUT_CYC);
    localparam bit               WDOG_EN  = (TIMEOUT_CYC > 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    arb_state_e          state_q, state_d;
    owner_e              owner_q, owner_d;
    owner_e              last_grant_q, last_grant_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_wen_q, mem_wen_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W/8-1:0] mem_wmask_q, mem_wmask_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [1:0]          grant;
    logic                resp_fire;
    logic                resp_err;
    logic                timeout_hit;

    ysyx_23060191_rr_pick u_rr_pick (
        .ifu_valid  (ifu_req_valid),
        .lsu_valid  (lsu_req_valid),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    assign timeout_hit = WDOG_EN && (cnt_q == CNT_LAST);

    // Next-state, payload capture, handshakes and watchdog counting.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_grant_d  = last_grant_q;
        mem_addr_d    = mem_addr_q;
        mem_wen_d     = mem_wen_q;
        mem_wdata_d   = mem_wdata_q;
        mem_wmask_d   = mem_wmask_q;
        cnt_d         = cnt_q;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        mem_req_valid = 1'b0;
        resp_fire     = 1'b0;
        resp_err      = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (grant[0]) begin
                    // Fetches are always reads: force an empty write.
                    ifu_req_ready = 1'b1;
                    mem_addr_d    = ifu_addr;
                    mem_wen_d     = 1'b0;
                    mem_wdata_d   = '0;
                    mem_wmask_d   = '0;
                    owner_d       = OWN_IFU;
                    last_grant_d  = OWN_IFU;
                    state_d       = ARB_REQ;
                end else if (grant[1]) begin
                    lsu_req_ready = 1'b1;
                    mem_addr_d    = lsu_addr;
                    mem_wen_d     = lsu_wen;
                    mem_wdata_d   = lsu_wdata;
                    mem_wmask_d   = lsu_wmask;
                    owner_d       = OWN_LSU;
                    last_grant_d  = OWN_LSU;
                    state_d       = ARB_REQ;
                end
            end
            ARB_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                // A real response wins over a watchdog expiry in the same cycle.
                if (mem_resp_valid) begin
                    resp_fire = 1'b1;
                    state_d   = ARB_IDLE;
                end else if (timeout_hit) begin
                    resp_fire = 1'b1;
                    resp_err  = 1'b1;
                    state_d   = ARB_IDLE;
                end else if (WDOG_EN) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State, owner, payload and watchdog registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q      <= ARB_IDLE;
            owner_q      <= OWN_LSU;
            last_grant_q <= OWN_LSU;
            mem_addr_q   <= '0;
            mem_wen_q    <= 1'b0;
            mem_wdata_q  <= '0;
            mem_wmask_q  <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            mem_addr_q   <= mem_addr_d;
            mem_wen_q    <= mem_wen_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wmask_q  <= mem_wmask_d;
            cnt_q        <= cnt_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wen   = mem_wen_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wmask = mem_wmask_q;

    // Response demux: pulse only the owner; read data is zeroed on an error.
    assign ifu_resp_valid = resp_fire && (owner_q == OWN_IFU);
    assign lsu_resp_valid = resp_fire && (owner_q == OWN_LSU);
    assign ifu_err        = ifu_resp_valid && resp_err;
    assign lsu_err        = lsu_resp_valid && resp_err;
    assign ifu_rdata      = (ifu_resp_valid && !resp_err) ? mem_rdata : '0;
    assign lsu_rdata      = (lsu_resp_valid && !resp_err) ? mem_rdata : '0;

endmodule

// File: tb/tb_ysyx_23060191_mem_arbiter.sv
// Directed and randomized checks of the IFU/LSU memory arbiter.
module tb_ysyx_23060191_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_err;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_err;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        is_lsu;
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } txn_t;

    ysyx_23060191_mem_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_addr       (ifu_addr),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_rdata      (ifu_rdata),
        .ifu_err        (ifu_err),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_addr       (lsu_addr),
        .lsu_wen        (lsu_wen),
        .lsu_wdata      (lsu_wdata),
        .lsu_wmask      (lsu_wmask),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_rdata      (lsu_rdata),
        .lsu_err        (lsu_err),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_wen        (mem_wen),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; checks run 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_rdata(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5A5_0F0F;
    endfunction

    task automatic clear_inputs();
        ifu_req_valid  = 1'b0;
        ifu_addr       = '0;
        lsu_req_valid  = 1'b0;
        lsu_addr       = '0;
        lsu_wen        = 1'b0;
        lsu_wdata      = '0;
        lsu_wmask      = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Drives the memory through a REQ/WAIT pair from the REQ cycle onward.
    task automatic finish_txn(input logic [31:0] rdata);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = rdata;
        tick();
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        #1;
        n_checks++;
        if ({ifu_req_ready, lsu_req_ready, mem_req_valid, ifu_resp_valid, lsu_resp_valid,
             ifu_err, lsu_err} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got rdy/vld/err=%b want 0000000",
                     {ifu_req_ready, lsu_req_ready, mem_req_valid, ifu_resp_valid,
                      lsu_resp_valid, ifu_err, lsu_err});
        end
        n_checks++;
        if (mem_addr !== 32'h0 || mem_wen !== 1'b0 || mem_wdata !== 32'h0 || mem_wmask !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_payload: got addr=%h wen=%b wdata=%h wmask=%h want all 0",
                     mem_addr, mem_wen, mem_wdata, mem_wmask);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_ifu_only();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0000;
        mem_req_ready = 1'b1;
        #1;
        n_checks++;
        if (ifu_req_ready !== 1'b1 || lsu_req_ready !== 1'b0 || mem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ifu_accept_T: got ifu_rdy=%b lsu_rdy=%b mem_vld=%b want 1 0 0",
                     ifu_req_ready, lsu_req_ready, mem_req_valid);
        end
        tick();
        ifu_req_valid = 1'b0;
        #1;
        n_checks++;
        if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_0000 || mem_wen !== 1'b0 || mem_wmask !== 4'h0) begin
            n_fail++;
            $display("FAIL ifu_memreq_T1: got vld=%b addr=%h wen=%b wmask=%h want 1 80000000 0 0",
                     mem_req_valid, mem_addr, mem_wen, mem_wmask);
        end
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h0000_0413;
        #1;
        n_checks++;
        if (ifu_resp_valid !== 1'b1 || ifu_rdata !== 32'h0000_0413 || ifu_err !== 1'b0 || lsu_resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ifu_resp_T2: got vld=%b rdata=%h err=%b lsu_vld=%b want 1 00000413 0 0",
                     ifu_resp_valid, ifu_rdata, ifu_err, lsu_resp_valid);
        end
        tick();
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
        #1;
        n_checks++;
        if (ifu_resp_valid !== 1'b0 || lsu_resp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ifu_after_T3: got ifu_vld=%b lsu_vld=%b mem_vld=%b want 0 0 0",
                     ifu_resp_valid, lsu_resp_valid, mem_req_valid);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic        exp_lsu [0:2] = '{1'b0, 1'b1, 1'b0};
        logic [31:0] exp_addr;
        do_reset();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0100;
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h8000_2000;
        for (int i = 0; i < 3; i++) begin
            exp_addr = exp_lsu[i] ? 32'h8000_2000 : 32'h8000_0100;
            #1;
            n_checks++;
            if (ifu_req_ready !== !exp_lsu[i] || lsu_req_ready !== exp_lsu[i]) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: got ifu_rdy=%b lsu_rdy=%b want %b %b",
                         i, ifu_req_ready, lsu_req_ready, !exp_lsu[i], exp_lsu[i]);
            end
            tick();
            mem_req_ready = 1'b1;
            #1;
            n_checks++;
            if (mem_addr !== exp_addr || ifu_req_ready !== 1'b0 || lsu_req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_req[%0d]: got addr=%h rdy=%b%b want %h 00",
                         i, mem_addr, ifu_req_ready, lsu_req_ready, exp_addr);
            end
            tick();
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b1;
            mem_rdata      = 32'h0000_1000 + 32'(i);
            #1;
            n_checks++;
            if (exp_lsu[i] ? (lsu_resp_valid !== 1'b1 || ifu_resp_valid !== 1'b0 || lsu_rdata !== mem_rdata)
                           : (ifu_resp_valid !== 1'b1 || lsu_resp_valid !== 1'b0 || ifu_rdata !== mem_rdata)) begin
                n_fail++;
                $display("FAIL rr_resp[%0d]: got ifu_vld=%b lsu_vld=%b ifu_rd=%h lsu_rd=%h want owner lsu=%b data %h",
                         i, ifu_resp_valid, lsu_resp_valid, ifu_rdata, lsu_rdata, exp_lsu[i], 32'h1000 + i);
            end
            n_checks++;
            if (ifu_req_ready !== 1'b0 || lsu_req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_no_grant_on_resp[%0d]: got rdy=%b%b want 00", i, ifu_req_ready, lsu_req_ready);
            end
            tick();
            mem_resp_valid = 1'b0;
        end
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        tick();
    endtask

    task automatic test_store_stall();
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h8000_1000;
        lsu_wen       = 1'b1;
        lsu_wdata     = 32'hDEAD_BEEF;
        lsu_wmask     = 4'hF;
        #1;
        n_checks++;
        if (lsu_req_ready !== 1'b1 || ifu_req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL store_accept: got lsu_rdy=%b ifu_rdy=%b want 1 0", lsu_req_ready, ifu_req_ready);
        end
        tick();
        // Scramble the LSU inputs: the latched payload must not follow them.
        lsu_req_valid = 1'b0;
        lsu_addr      = 32'h0;
        lsu_wen       = 1'b0;
        lsu_wdata     = 32'h0;
        lsu_wmask     = 4'h0;
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0004;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_1000 || mem_wen !== 1'b1 ||
                mem_wdata !== 32'hDEAD_BEEF || mem_wmask !== 4'hF || ifu_req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL store_stall[%0d]: got vld=%b addr=%h wen=%b wdata=%h wmask=%h ifu_rdy=%b want 1 80001000 1 deadbeef f 0",
                         i, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, ifu_req_ready);
            end
            tick();
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h0;
        #1;
        n_checks++;
        if (lsu_resp_valid !== 1'b1 || lsu_err !== 1'b0 || ifu_resp_valid !== 1'b0 || ifu_req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL store_resp: got lsu_vld=%b lsu_err=%b ifu_vld=%b ifu_rdy=%b want 1 0 0 0",
                     lsu_resp_valid, lsu_err, ifu_resp_valid, ifu_req_ready);
        end
        tick();
        mem_resp_valid = 1'b0;
        #1;
        n_checks++;
        if (ifu_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL store_ifu_next: got ifu_rdy=%b want 1", ifu_req_ready);
        end
        tick();
        ifu_req_valid = 1'b0;
        finish_txn(32'h0000_0013);
    endtask

    task automatic test_timeout();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0008;
        #1;
        n_checks++;
        if (ifu_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_accept: got ifu_rdy=%b want 1", ifu_req_ready);
        end
        tick();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_rdata     = 32'hFFFF_FFFF;
        for (int k = 1; k <= 8; k++) begin
            #1;
            n_checks++;
            if (k < 8) begin
                if (ifu_resp_valid !== 1'b0 || lsu_resp_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL tmo_early[%0d]: got ifu_vld=%b lsu_vld=%b want 0 0", k, ifu_resp_valid, lsu_resp_valid);
                end
            end else begin
                if (ifu_resp_valid !== 1'b1 || ifu_err !== 1'b1 || ifu_rdata !== 32'h0 || lsu_resp_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL tmo_fire: got vld=%b err=%b rdata=%h lsu_vld=%b want 1 1 00000000 0",
                             ifu_resp_valid, ifu_err, ifu_rdata, lsu_resp_valid);
                end
            end
            tick();
        end
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h0000_1234;
        #1;
        n_checks++;
        if (ifu_resp_valid !== 1'b0 || lsu_resp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_late_resp: got ifu_vld=%b lsu_vld=%b mem_vld=%b want 0 0 0",
                     ifu_resp_valid, lsu_resp_valid, mem_req_valid);
        end
        tick();
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_000C;
        tick();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        rst           = 1'b1;
        tick();
        rst            = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h0000_ABCD;
        #1;
        n_checks++;
        if ({ifu_req_ready, lsu_req_ready, mem_req_valid, ifu_resp_valid, lsu_resp_valid,
             ifu_err, lsu_err} !== 7'b0 || mem_addr !== 32'h0 || mem_wen !== 1'b0 ||
            mem_wdata !== 32'h0 || mem_wmask !== 4'h0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got ctl=%b addr=%h wen=%b wdata=%h wmask=%h want all 0",
                     {ifu_req_ready, lsu_req_ready, mem_req_valid, ifu_resp_valid, lsu_resp_valid,
                      ifu_err, lsu_err}, mem_addr, mem_wen, mem_wdata, mem_wmask);
        end
        tick();
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
        ifu_req_valid  = 1'b1;
        ifu_addr       = 32'h8000_0010;
        #1;
        n_checks++;
        if (ifu_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_reaccept: got ifu_rdy=%b want 1", ifu_req_ready);
        end
        tick();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        n_checks++;
        if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_0010) begin
            n_fail++;
            $display("FAIL rst_mid_req: got vld=%b addr=%h want 1 80000010", mem_req_valid, mem_addr);
        end
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h0010_0093;
        #1;
        n_checks++;
        if (ifu_resp_valid !== 1'b1 || ifu_rdata !== 32'h0010_0093 || ifu_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_resp: got vld=%b rdata=%h err=%b want 1 00100093 0",
                     ifu_resp_valid, ifu_rdata, ifu_err);
        end
        tick();
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
        tick();
    endtask

    task automatic test_random();
        txn_t exp_q[$];
        txn_t cur;
        logic ifu_pend = 1'b0;
        logic lsu_pend = 1'b0;
        logic in_wait  = 1'b0;
        logic legit;
        int   wait_idx = 0;
        int   delay    = 0;
        int   n_acc    = 0;
        int   n_resp   = 0;
        cur = '{1'b0, 32'h0, 1'b0, 32'h0, 4'h0};
        for (int cyc = 0; cyc < 3200; cyc++) begin
            if (cyc < 3000) begin
                if (!ifu_pend && $urandom_range(0, 2) == 0) begin
                    ifu_pend = 1'b1;
                    ifu_addr = $urandom & ~32'h3;
                end
                if (!lsu_pend && $urandom_range(0, 2) == 0) begin
                    lsu_pend  = 1'b1;
                    lsu_addr  = $urandom;
                    lsu_wen   = 1'($urandom_range(0, 1));
                    lsu_wdata = $urandom;
                    lsu_wmask = 4'($urandom_range(0, 15));
                end
            end
            ifu_req_valid  = ifu_pend;
            lsu_req_valid  = lsu_pend;
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            mem_rdata      = $urandom;
            legit          = 1'b0;
            if (in_wait) begin
                if (wait_idx == delay) begin
                    mem_resp_valid = 1'b1;
                    mem_rdata      = model_rdata(cur.addr);
                    legit          = 1'b1;
                end
            end else begin
                mem_req_ready  = mem_req_valid ? 1'($urandom_range(0, 1)) : 1'b0;
                mem_resp_valid = ($urandom_range(0, 7) == 0);
            end
            #1;
            n_checks++;
            if ((ifu_req_ready && lsu_req_ready) || (ifu_req_ready && !ifu_pend) || (lsu_req_ready && !lsu_pend)) begin
                n_fail++;
                $display("FAIL rand_ready cyc %0d: got rdy=%b%b pend=%b%b", cyc,
                         ifu_req_ready, lsu_req_ready, ifu_pend, lsu_pend);
            end
            if (ifu_req_ready === 1'b1) begin
                exp_q.push_back('{1'b0, ifu_addr, 1'b0, 32'h0, 4'h0});
                ifu_pend = 1'b0;
                n_acc++;
            end
            if (lsu_req_ready === 1'b1) begin
                exp_q.push_back('{1'b1, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask});
                lsu_pend = 1'b0;
                n_acc++;
            end
            if (mem_req_valid && mem_req_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_payload cyc %0d: memory request with no accepted transaction", cyc);
                end else begin
                    cur = exp_q.pop_front();
                    if (mem_addr !== cur.addr || mem_wen !== cur.wen || mem_wmask !== cur.wmask ||
                        (cur.wen && mem_wdata !== cur.wdata)) begin
                        n_fail++;
                        $display("FAIL rand_payload cyc %0d: got %h/%b/%h/%h want %h/%b/%h/%h", cyc,
                                 mem_addr, mem_wen, mem_wdata, mem_wmask, cur.addr, cur.wen, cur.wdata, cur.wmask);
                    end
                end
                in_wait  = 1'b1;
                wait_idx = 0;
                delay    = $urandom_range(0, 4);
            end else if (in_wait) begin
                if (legit) begin
                    n_checks++;
                    if (cur.is_lsu ? (lsu_resp_valid !== 1'b1 || ifu_resp_valid !== 1'b0 || lsu_err !== 1'b0 ||
                                      (!cur.wen && lsu_rdata !== model_rdata(cur.addr)))
                                   : (ifu_resp_valid !== 1'b1 || lsu_resp_valid !== 1'b0 || ifu_err !== 1'b0 ||
                                      ifu_rdata !== model_rdata(cur.addr))) begin
                        n_fail++;
                        $display("FAIL rand_resp cyc %0d: got ifu %b/%h/%b lsu %b/%h/%b want owner lsu=%b data %h", cyc,
                                 ifu_resp_valid, ifu_rdata, ifu_err, lsu_resp_valid, lsu_rdata, lsu_err,
                                 cur.is_lsu, model_rdata(cur.addr));
                    end
                    in_wait = 1'b0;
                    n_resp++;
                end else begin
                    wait_idx++;
                end
            end
            if (!legit) begin
                n_checks++;
                if (ifu_resp_valid !== 1'b0 || lsu_resp_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_spurious cyc %0d: got ifu_vld=%b lsu_vld=%b want 0 0", cyc,
                             ifu_resp_valid, lsu_resp_valid);
                end
            end
            tick();
        end
        clear_inputs();
        n_checks++;
        if (exp_q.size() != 0 || in_wait || ifu_pend || lsu_pend || n_resp != n_acc) begin
            n_fail++;
            $display("FAIL rand_drain: got accepted=%0d responded=%0d queued=%0d busy=%b%b%b want all drained",
                     n_acc, n_resp, exp_q.size(), in_wait, ifu_pend, lsu_pend);
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_ifu_only();
        test_back_to_back();
        test_store_stall();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
